// File: rtl/ltssm_pkg.sv
// Purpose: shared constants for the receive-side LTSSM (substate codes, TS symbols, byte offsets).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ltssm_pkg;

  // Substate codes as commanded by the main LTSSM
  typedef enum logic [4:0] {
    detectQuiet          = 5'd0,
    detectActive         = 5'd1,
    pollingActive        = 5'd2,
    pollingConfiguration = 5'd3,
    cfgLinkWidthStart    = 5'd4,
    cfgLinkWidthAccept   = 5'd5,
    cfgLanenumWait       = 5'd6,
    cfgLanenumAccept     = 5'd7,
    cfgComplete          = 5'd8,
    cfgIdle              = 5'd9
  } substate_e;

  // exitTo codes that do not simply follow the substate sequence
  localparam logic [3:0] EXIT_DETECT = 4'd0;
  localparam logic [3:0] EXIT_L0     = 4'd10;

  // Ordered-set symbol values
  localparam logic [7:0] TS1_ID = 8'h2A;
  localparam logic [7:0] TS2_ID = 8'h25;
  localparam logic [7:0] PAD    = 8'hF7;

  // Byte offsets within one 128-bit lane (byte0 = COM, byte3 = N_FTS are not inspected)
  localparam int B_LINK   = 1;
  localparam int B_LANE   = 2;
  localparam int B_RATE   = 4;
  localparam int B_EQ     = 6;   // [2:0] receiver preset hint, [6:3] transmitter preset
  localparam int B_FS_PRE = 7;   // FS value / pre-cursor coefficient
  localparam int B_LF_CUR = 8;   // LF value / cursor coefficient
  localparam int B_POST   = 9;   // post-cursor coefficient
  localparam int B_ID     = 15;

  // Consecutive-set targets
  localparam logic [3:0] SETS_SHORT = 4'd2;
  localparam logic [3:0] SETS_LONG  = 4'd8;

  // Pick one byte out of a lane
  function automatic logic [7:0] laneByte(input logic [127:0] lane, input int idx);
    return lane[8*idx +: 8];
  endfunction

endpackage

// File: rtl/rx_lane_qualifier.sv
// Purpose: decides whether one lane's ordered set satisfies the current substate's match rule.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, validity is handled by the caller.
module rx_lane_qualifier
  import ltssm_pkg::*;
#(
  parameter int DEVICE_TYPE = 0
) (
  input  logic [127:0] laneData,
  input  logic [4:0]   substate,
  input  logic [7:0]   linkNumber,
  input  logic [3:0]   laneIndex,
  output logic         qualifies
);

  logic [7:0] linkB;
  logic [7:0] laneB;
  logic [7:0] idB;

  assign linkB = laneByte(laneData, B_LINK);
  assign laneB = laneByte(laneData, B_LANE);
  assign idB   = laneByte(laneData, B_ID);

  // Per-substate match rule for this lane
  always_comb begin
    qualifies = 1'b0;
    case (substate)
      pollingActive:
        qualifies = (idB == TS1_ID || idB == TS2_ID) && linkB == PAD && laneB == PAD;
      pollingConfiguration:
        qualifies = idB == TS2_ID && linkB == PAD && laneB == PAD;
      cfgLinkWidthStart:
        // An upstream port adopts whatever link number the partner offers
        qualifies = idB == TS1_ID && linkB != PAD && laneB == PAD &&
                    (DEVICE_TYPE == 1 || linkB == linkNumber);
      cfgLinkWidthAccept:
        qualifies = idB == TS1_ID && linkB == linkNumber;
      cfgLanenumWait:
        qualifies = idB == TS1_ID && linkB == linkNumber && laneB != PAD;
      cfgLanenumAccept:
        qualifies = idB == TS1_ID && linkB == linkNumber && laneB == {4'd0, laneIndex};
      cfgComplete:
        qualifies = idB == TS2_ID && linkB == linkNumber && laneB == {4'd0, laneIndex};
      cfgIdle:
        qualifies = laneData == '0;
      default:
        qualifies = 1'b0;
    endcase
  end

endmodule

// File: rtl/rx_ltssm.sv
// Purpose: receive-side LTSSM; counts consecutive qualifying ordered sets, flags substate exit, captures partner fields.
// Latency: finish/exitTo and write strobes register one cycle after the exit condition is seen.
// Backpressure: none; cycles with validOrderedSets low hold the count, the timer keeps running.
module rx_ltssm
  import ltssm_pkg::*;
#(
  parameter int DEVICE_TYPE   = 0,
  parameter int CYCLES_PER_MS = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] orderedSets,
  input  logic [4:0]    numberOfDetectedLanes,
  input  logic [4:0]    substate,
  input  logic [7:0]    linkNumber,
  input  logic [2:0]    Gen,
  input  logic          rxElectricalIdle,
  input  logic          validOrderedSets,
  output logic [7:0]    rateId,
  output logic          upConfigureCapability,
  output logic          finish,
  output logic [3:0]    exitTo,
  output logic          witeUpconfigureCapability,
  output logic          writerateid,
  output logic          writeLinkNumber,
  output logic          lpifStatus,
  output logic [2:0]    ReceiverpresetHintDSP,
  output logic [3:0]    TransmitterPresetHintDSP,
  output logic [2:0]    ReceiverpresetHintUSP,
  output logic [3:0]    TransmitterPresetHintUSP,
  output logic          writeReceiverpresetHintDSP,
  output logic          writeTransmitterPresetHintDSP,
  output logic          writeReceiverpresetHintUSP,
  output logic          writeTransmitterPresetHintUSP,
  output logic [5:0]    LFDSP,
  output logic [5:0]    FSDSP,
  output logic [5:0]    CursorCoff,
  output logic [5:0]    PreCursorCoff,
  output logic [5:0]    PostCursorCoff
);

  localparam int TMR_W = $clog2(48 * CYCLES_PER_MS + 1);
  // Timeout fires in the last cycle of the window so finish shows on the cycle after it
  localparam logic [TMR_W-1:0] T24 = TMR_W'(24 * CYCLES_PER_MS - 1);
  localparam logic [TMR_W-1:0] T48 = TMR_W'(48 * CYCLES_PER_MS - 1);

  logic [4:0]       substateQ;
  logic             substateChg;
  logic [3:0]       setCount;
  logic [3:0]       countBase;
  logic [3:0]       countNext;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timerBase;
  logic [15:0]      laneQual;
  logic [15:0]      laneUsed;
  logic             allQual;
  logic             exitCond;
  logic [3:0]       exitCode;
  logic             finishHeld;
  logic             finishRise;
  logic             linkStrobe;
  logic             rateStrobe;
  logic             eqStrobe;
  logic             idleDone;

  for (genvar i = 0; i < 16; i++) begin : gLane
    rx_lane_qualifier #(.DEVICE_TYPE(DEVICE_TYPE)) uQual (
      .laneData  (orderedSets[128*i +: 128]),
      .substate  (substate),
      .linkNumber(linkNumber),
      .laneIndex (4'(i)),
      .qualifies (laneQual[i])
    );
    assign laneUsed[i] = 5'(i) < numberOfDetectedLanes;
  end

  // Every active lane must match; unused lanes are don't-care
  assign allQual = (numberOfDetectedLanes != 5'd0) && ((laneQual | ~laneUsed) == 16'hFFFF);

  // Consecutive-set counter and substate timer, both restarting on a substate change
  always_comb begin
    substateChg = substate != substateQ;
    countBase   = substateChg ? 4'd0 : setCount;
    timerBase   = substateChg ? '0 : timer;
    countNext   = countBase;
    if (validOrderedSets) begin
      if (allQual) countNext = (countBase == 4'hF) ? countBase : countBase + 4'd1;
      else         countNext = 4'd0;
    end
  end

  // Exit condition and target for the commanded substate; a count win beats a timeout
  always_comb begin
    exitCond = 1'b0;
    exitCode = EXIT_DETECT;
    case (substate)
      detectQuiet: begin
        exitCond = !rxElectricalIdle;
        exitCode = 4'd1;
      end
      detectActive: begin
        exitCond = 1'b1;
        exitCode = 4'd2;
      end
      pollingActive: begin
        if (countNext >= SETS_LONG) begin
          exitCond = 1'b1;
          exitCode = 4'd3;
        end else if (timerBase >= T24) begin
          exitCond = 1'b1;
        end
      end
      pollingConfiguration: begin
        if (countNext >= SETS_LONG) begin
          exitCond = 1'b1;
          exitCode = 4'd4;
        end else if (timerBase >= T48) begin
          exitCond = 1'b1;
        end
      end
      cfgLinkWidthStart, cfgLinkWidthAccept, cfgLanenumWait, cfgLanenumAccept: begin
        if (countNext >= SETS_SHORT) begin
          exitCond = 1'b1;
          exitCode = 4'(substate + 5'd1);
        end else if (timerBase >= T24) begin
          exitCond = 1'b1;
        end
      end
      cfgComplete: begin
        if (countNext >= SETS_LONG) begin
          exitCond = 1'b1;
          exitCode = 4'd9;
        end else if (timerBase >= T24) begin
          exitCond = 1'b1;
        end
      end
      cfgIdle: begin
        if (countNext >= SETS_LONG) begin
          exitCond = 1'b1;
          exitCode = EXIT_L0;
        end
      end
      default: begin
        exitCond = 1'b0;
      end
    endcase
  end

  // finish latches on the first qualifying cycle; strobes only accompany that rise
  always_comb begin
    finishHeld = finish && !substateChg;
    finishRise = exitCond && !finishHeld;
    linkStrobe = finishRise && substate == cfgLinkWidthStart && exitCode == 4'd5 && DEVICE_TYPE == 1;
    rateStrobe = finishRise && substate == cfgComplete && exitCode == 4'd9;
    eqStrobe   = rateStrobe && Gen >= 3'd3;
    idleDone   = finishRise && substate == cfgIdle;
  end

  // Counter, timer and exit outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      substateQ  <= 5'd0;
      setCount   <= 4'd0;
      timer      <= '0;
      finish     <= 1'b0;
      exitTo     <= 4'd0;
      lpifStatus <= 1'b0;
    end else begin
      substateQ <= substate;
      setCount  <= countNext;
      timer     <= (timerBase == '1) ? timerBase : timerBase + TMR_W'(1);
      finish    <= finishHeld || finishRise;
      if (finishRise)       exitTo <= exitCode;
      else if (substateChg) exitTo <= 4'd0;
      // Link-up stays asserted through L0 and later retraining until the link falls back to detect
      if (substate == detectQuiet) lpifStatus <= 1'b0;
      else if (idleDone)           lpifStatus <= 1'b1;
    end
  end

  // Link-partner field capture with single-cycle write strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rateId                    <= 8'd0;
      upConfigureCapability     <= 1'b0;
      writerateid               <= 1'b0;
      witeUpconfigureCapability <= 1'b0;
      writeLinkNumber           <= 1'b0;
    end else begin
      writerateid               <= rateStrobe;
      witeUpconfigureCapability <= rateStrobe;
      writeLinkNumber           <= linkStrobe;
      if (rateStrobe) begin
        rateId                <= orderedSets[8*B_RATE +: 8];
        upConfigureCapability <= orderedSets[8*B_RATE + 6];
      end
    end
  end

  // Equalisation fields from lane 0 at Gen3+; the partner's values land in the opposite port's outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReceiverpresetHintDSP         <= 3'd0;
      TransmitterPresetHintDSP      <= 4'd0;
      ReceiverpresetHintUSP         <= 3'd0;
      TransmitterPresetHintUSP      <= 4'd0;
      writeReceiverpresetHintDSP    <= 1'b0;
      writeTransmitterPresetHintDSP <= 1'b0;
      writeReceiverpresetHintUSP    <= 1'b0;
      writeTransmitterPresetHintUSP <= 1'b0;
      LFDSP                         <= 6'd0;
      FSDSP                         <= 6'd0;
      CursorCoff                    <= 6'd0;
      PreCursorCoff                 <= 6'd0;
      PostCursorCoff                <= 6'd0;
    end else begin
      writeReceiverpresetHintDSP    <= eqStrobe && DEVICE_TYPE == 1;
      writeTransmitterPresetHintDSP <= eqStrobe && DEVICE_TYPE == 1;
      writeReceiverpresetHintUSP    <= eqStrobe && DEVICE_TYPE != 1;
      writeTransmitterPresetHintUSP <= eqStrobe && DEVICE_TYPE != 1;
      if (eqStrobe) begin
        if (DEVICE_TYPE == 1) begin
          ReceiverpresetHintDSP    <= orderedSets[8*B_EQ +: 3];
          TransmitterPresetHintDSP <= orderedSets[8*B_EQ + 3 +: 4];
        end else begin
          ReceiverpresetHintUSP    <= orderedSets[8*B_EQ +: 3];
          TransmitterPresetHintUSP <= orderedSets[8*B_EQ + 3 +: 4];
        end
        FSDSP          <= orderedSets[8*B_FS_PRE +: 6];
        LFDSP          <= orderedSets[8*B_LF_CUR +: 6];
        PreCursorCoff  <= orderedSets[8*B_FS_PRE +: 6];
        CursorCoff     <= orderedSets[8*B_LF_CUR +: 6];
        PostCursorCoff <= orderedSets[8*B_POST +: 6];
      end
    end
  end

endmodule

// File: tb/tb_rx_ltssm.sv
// Purpose: directed self-checking bench for rx_ltssm (downstream port, 10 cycles per ms).
// Latency: checks sample #1 after the clock edge that registers each applied cycle.
// Backpressure: n/a.
module tb_rx_ltssm;

  logic          clk;
  logic          reset;
  logic [2047:0] orderedSets;
  logic [4:0]    numberOfDetectedLanes;
  logic [4:0]    substate;
  logic [7:0]    linkNumber;
  logic [2:0]    Gen;
  logic          rxElectricalIdle;
  logic          validOrderedSets;
  logic [7:0]    rateId;
  logic          upConfigureCapability;
  logic          finish;
  logic [3:0]    exitTo;
  logic          witeUpconfigureCapability;
  logic          writerateid;
  logic          writeLinkNumber;
  logic          lpifStatus;
  logic [2:0]    ReceiverpresetHintDSP;
  logic [3:0]    TransmitterPresetHintDSP;
  logic [2:0]    ReceiverpresetHintUSP;
  logic [3:0]    TransmitterPresetHintUSP;
  logic          writeReceiverpresetHintDSP;
  logic          writeTransmitterPresetHintDSP;
  logic          writeReceiverpresetHintUSP;
  logic          writeTransmitterPresetHintUSP;
  logic [5:0]    LFDSP;
  logic [5:0]    FSDSP;
  logic [5:0]    CursorCoff;
  logic [5:0]    PreCursorCoff;
  logic [5:0]    PostCursorCoff;

  int passCnt = 0;
  int totalCnt = 0;

  rx_ltssm #(.DEVICE_TYPE(0), .CYCLES_PER_MS(10)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .orderedSets                  (orderedSets),
    .numberOfDetectedLanes        (numberOfDetectedLanes),
    .substate                     (substate),
    .linkNumber                   (linkNumber),
    .Gen                          (Gen),
    .rxElectricalIdle             (rxElectricalIdle),
    .validOrderedSets             (validOrderedSets),
    .rateId                       (rateId),
    .upConfigureCapability        (upConfigureCapability),
    .finish                       (finish),
    .exitTo                       (exitTo),
    .witeUpconfigureCapability    (witeUpconfigureCapability),
    .writerateid                  (writerateid),
    .writeLinkNumber              (writeLinkNumber),
    .lpifStatus                   (lpifStatus),
    .ReceiverpresetHintDSP        (ReceiverpresetHintDSP),
    .TransmitterPresetHintDSP     (TransmitterPresetHintDSP),
    .ReceiverpresetHintUSP        (ReceiverpresetHintUSP),
    .TransmitterPresetHintUSP     (TransmitterPresetHintUSP),
    .writeReceiverpresetHintDSP   (writeReceiverpresetHintDSP),
    .writeTransmitterPresetHintDSP(writeTransmitterPresetHintDSP),
    .writeReceiverpresetHintUSP   (writeReceiverpresetHintUSP),
    .writeTransmitterPresetHintUSP(writeTransmitterPresetHintUSP),
    .LFDSP                        (LFDSP),
    .FSDSP                        (FSDSP),
    .CursorCoff                   (CursorCoff),
    .PreCursorCoff                (PreCursorCoff),
    .PostCursorCoff               (PostCursorCoff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build all 16 lanes: lane number is PAD or the lane index
  function automatic logic [2047:0] mkSets(input logic [7:0] id, input logic [7:0] link,
                                           input logic laneIsIdx, input logic [7:0] rate,
                                           input logic [7:0] eq);
    logic [2047:0] s;
    logic [127:0]  l;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      l = '0;
      l[7:0]     = 8'hBC;
      l[15:8]    = link;
      l[23:16]   = laneIsIdx ? 8'(i) : 8'hF7;
      l[31:24]   = 8'h18;
      l[39:32]   = rate;
      l[55:48]   = eq;
      l[127:120] = id;
      s[128*i +: 128] = l;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL rst_finish got %b want 0", finish); else passCnt++;
    totalCnt++; if (exitTo !== 4'd0) $display("FAIL rst_exitTo got %0d want 0", exitTo); else passCnt++;
    totalCnt++; if (rateId !== 8'd0) $display("FAIL rst_rateId got %h want 00", rateId); else passCnt++;
    totalCnt++; if (lpifStatus !== 1'b0) $display("FAIL rst_lpif got %b want 0", lpifStatus); else passCnt++;
    reset = 1'b1;
    // Begin a pollingConfiguration count, then reset in the middle of it
    substate = 5'd3;
    validOrderedSets = 1'b1;
    orderedSets = mkSets(8'h25, 8'hF7, 1'b0, 8'h00, 8'h00);
    repeat (5) step();
    reset = 1'b0;
    step();
    totalCnt++; if (finish !== 1'b0 || exitTo !== 4'd0) $display("FAIL rst_mid got finish=%b exitTo=%0d want 0/0", finish, exitTo); else passCnt++;
    reset = 1'b1;
    repeat (7) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL pcfg_after7 got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd4) $display("FAIL pcfg_after8 got finish=%b exitTo=%0d want 1/4", finish, exitTo); else passCnt++;
    validOrderedSets = 1'b0;
    repeat (3) step();
    totalCnt++; if (finish !== 1'b1) $display("FAIL pcfg_held got %b want 1", finish); else passCnt++;
  endtask

  task automatic test_hold_and_lanes();
    logic [2047:0] good;
    logic [2047:0] badLane1;
    substate = 5'd0; rxElectricalIdle = 1'b1; validOrderedSets = 1'b0;
    step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL chg_clears got %b want 0", finish); else passCnt++;
    good = mkSets(8'h25, 8'hF7, 1'b0, 8'h00, 8'h00);
    good[128*5 + 120 +: 8] = 8'h00;    // lane 5 is outside N=2 and must be ignored
    badLane1 = good;
    badLane1[128*1 + 120 +: 8] = 8'h2A; // only lane 1 carries a TS1
    substate = 5'd3; orderedSets = good;
    validOrderedSets = 1'b1; repeat (4) step();
    validOrderedSets = 1'b0; repeat (2) step();
    orderedSets = badLane1; validOrderedSets = 1'b1; step();
    orderedSets = good; repeat (7) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL lane1_clear got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd4) $display("FAIL lane_mask got finish=%b exitTo=%0d want 1/4", finish, exitTo); else passCnt++;
    // Hold across invalid cycles: 4 sets, 3 idle cycles, 4 sets
    substate = 5'd0; validOrderedSets = 1'b0; step();
    substate = 5'd3; validOrderedSets = 1'b1; repeat (4) step();
    validOrderedSets = 1'b0; repeat (3) step();
    validOrderedSets = 1'b1; repeat (3) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL hold_7 got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1) $display("FAIL hold_8 got %b want 1", finish); else passCnt++;
  endtask

  task automatic test_detect();
    validOrderedSets = 1'b0;
    substate = 5'd0; rxElectricalIdle = 1'b0;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd1) $display("FAIL dquiet got finish=%b exitTo=%0d want 1/1", finish, exitTo); else passCnt++;
    substate = 5'd1;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd2) $display("FAIL dactive got finish=%b exitTo=%0d want 1/2", finish, exitTo); else passCnt++;
    substate = 5'd15; validOrderedSets = 1'b1;
    orderedSets = mkSets(8'h2A, 8'hBB, 1'b1, 8'h00, 8'h00);
    repeat (3) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL unknown got %b want 0", finish); else passCnt++;
    substate = 5'd0; rxElectricalIdle = 1'b1; validOrderedSets = 1'b0;
    step();
  endtask

  task automatic test_lwstart();
    logic [2047:0] ts1;
    ts1 = mkSets(8'h2A, 8'hBB, 1'b0, 8'h00, 8'h00);
    substate = 5'd4; validOrderedSets = 1'b1;
    orderedSets = ts1; step();
    orderedSets = mkSets(8'h00, 8'hBB, 1'b0, 8'h00, 8'h00); step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL lws_bad1 got %b want 0", finish); else passCnt++;
    step();
    orderedSets = ts1; step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL lws_one got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd5) $display("FAIL lws_two got finish=%b exitTo=%0d want 1/5", finish, exitTo); else passCnt++;
    totalCnt++; if (writeLinkNumber !== 1'b0) $display("FAIL lws_dsp_wln got %b want 0", writeLinkNumber); else passCnt++;
    // A DSP rejects a link number other than its own
    substate = 5'd0; validOrderedSets = 1'b0; step();
    substate = 5'd4; validOrderedSets = 1'b1;
    orderedSets = mkSets(8'h2A, 8'hAA, 1'b0, 8'h00, 8'h00);
    repeat (4) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL lws_wronglink got %b want 0", finish); else passCnt++;
  endtask

  task automatic test_complete(input logic [2:0] gen, input logic [7:0] rate, input logic [7:0] eq);
    substate = 5'd0; validOrderedSets = 1'b0; step();
    Gen = gen;
    substate = 5'd8; validOrderedSets = 1'b1;
    orderedSets = mkSets(8'h25, 8'hBB, 1'b1, rate, eq);
    repeat (7) step();
    totalCnt++; if (finish !== 1'b0 || writerateid !== 1'b0) $display("FAIL cmp7 got finish=%b wr=%b want 0/0", finish, writerateid); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd9) $display("FAIL cmp8 got finish=%b exitTo=%0d want 1/9", finish, exitTo); else passCnt++;
    totalCnt++; if (rateId !== rate || upConfigureCapability !== rate[6]) $display("FAIL cmp_rate got %h/%b want %h/%b", rateId, upConfigureCapability, rate, rate[6]); else passCnt++;
    totalCnt++; if (writerateid !== 1'b1 || witeUpconfigureCapability !== 1'b1) $display("FAIL cmp_strobe got %b/%b want 1/1", writerateid, witeUpconfigureCapability); else passCnt++;
    if (gen >= 3'd3) begin
      totalCnt++; if (ReceiverpresetHintUSP !== eq[2:0] || TransmitterPresetHintUSP !== eq[6:3] || writeTransmitterPresetHintUSP !== 1'b1)
        $display("FAIL cmp_eq got rx=%0d tx=%0d wr=%b want %0d/%0d/1", ReceiverpresetHintUSP, TransmitterPresetHintUSP, writeTransmitterPresetHintUSP, eq[2:0], eq[6:3]); else passCnt++;
    end else begin
      totalCnt++; if (ReceiverpresetHintUSP !== 3'd0 || writeReceiverpresetHintUSP !== 1'b0)
        $display("FAIL cmp_eq_gen1 got rx=%0d wr=%b want 0/0", ReceiverpresetHintUSP, writeReceiverpresetHintUSP); else passCnt++;
    end
    step();
    totalCnt++; if (writerateid !== 1'b0 || finish !== 1'b1) $display("FAIL cmp_pulse got wr=%b finish=%b want 0/1", writerateid, finish); else passCnt++;
  endtask

  task automatic test_idle();
    substate = 5'd9; validOrderedSets = 1'b1; orderedSets = '0;
    repeat (7) step();
    totalCnt++; if (finish !== 1'b0 || lpifStatus !== 1'b0) $display("FAIL idle7 got finish=%b lpif=%b want 0/0", finish, lpifStatus); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd10 || lpifStatus !== 1'b1) $display("FAIL idle8 got finish=%b exitTo=%0d lpif=%b want 1/10/1", finish, exitTo, lpifStatus); else passCnt++;
    substate = 5'd8; validOrderedSets = 1'b0; step();
    totalCnt++; if (lpifStatus !== 1'b1) $display("FAIL lpif_hold got %b want 1", lpifStatus); else passCnt++;
    substate = 5'd0; step();
    totalCnt++; if (lpifStatus !== 1'b0) $display("FAIL lpif_clear got %b want 0", lpifStatus); else passCnt++;
  endtask

  task automatic test_timeout();
    substate = 5'd2; validOrderedSets = 1'b0;
    repeat (239) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL pact_to_early got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd0) $display("FAIL pact_to got finish=%b exitTo=%0d want 1/0", finish, exitTo); else passCnt++;
    substate = 5'd3;
    repeat (479) step();
    totalCnt++; if (finish !== 1'b0) $display("FAIL pcfg_to_early got %b want 0", finish); else passCnt++;
    step();
    totalCnt++; if (finish !== 1'b1 || exitTo !== 4'd0) $display("FAIL pcfg_to got finish=%b exitTo=%0d want 1/0", finish, exitTo); else passCnt++;
  endtask

  initial begin
    reset = 1'b0;
    orderedSets = '0;
    numberOfDetectedLanes = 5'd2;
    substate = 5'd0;
    linkNumber = 8'hBB;
    Gen = 3'd1;
    rxElectricalIdle = 1'b1;
    validOrderedSets = 1'b0;
    test_reset();
    test_hold_and_lanes();
    test_detect();
    test_lwstart();
    test_complete(3'd1, 8'hAA, 8'h5B);
    test_complete(3'd3, 8'h40, 8'h5B);
    test_idle();
    test_timeout();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
